// File: rtl/signed_bcd_converter_if.sv
// Handshake and result bus between the product source and the signed BCD converter.
// The master drives start/Result; the slave returns the sign, magnitude and packed BCD.
interface signed_bcd_converter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      Result;
    logic                  SignValue;
    logic [WIDTH-1:0]      Value;
    logic [4*DIGITS-1:0]   Bcd;
    logic                  busy;
    logic                  done;

    modport master (
        output start, Result,
        input  SignValue, Value, Bcd, busy, done
    );

    modport slave (
        input  start, Result,
        output SignValue, Value, Bcd, busy, done
    );
endinterface

// File: rtl/signed_bcd_converter.sv
// Captures a signed product, splits sign/magnitude and converts the magnitude to packed BCD
// with a one-bit-per-clock double-dabble loop. Displayed outputs change only on completion.
module signed_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    signed_bcd_converter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state_reg;
    logic [CW-1:0]         cnt_reg;
    logic [WIDTH-1:0]      bin_reg;
    logic [4*DIGITS-1:0]   scratch_reg;
    logic                  sign_reg;
    logic [WIDTH-1:0]      mag_reg;
    logic                  sign_out_reg;
    logic [WIDTH-1:0]      value_out_reg;
    logic [4*DIGITS-1:0]   bcd_out_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  result_neg;
    logic [WIDTH-1:0]      result_mag;
    logic [4*DIGITS-1:0]   scratch_adj;

    assign result_neg = bus.Result[WIDTH-1];
    // The most-negative value negates to itself, which as unsigned is exactly 2^(WIDTH-1).
    assign result_mag = result_neg ? ((~bus.Result) + {{(WIDTH-1){1'b0}}, 1'b1})
                                   : bus.Result;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                          ? scratch_reg[gi*4 +: 4] + 4'd3
                                          : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bin_reg       <= '0;
            scratch_reg   <= '0;
            sign_reg      <= 1'b0;
            mag_reg       <= '0;
            sign_out_reg  <= 1'b0;
            value_out_reg <= '0;
            bcd_out_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // busy drops one cycle after IDLE is re-entered, so it spans the done cycle.
                    busy_reg <= bus.start;
                    if (bus.start) begin
                        sign_reg    <= result_neg;
                        mag_reg     <= result_mag;
                        bin_reg     <= result_mag;
                        scratch_reg <= '0;
                        cnt_reg     <= CW'(WIDTH);
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy_reg <= 1'b1;
                    {scratch_reg, bin_reg} <= {scratch_adj[4*DIGITS-2:0], bin_reg, 1'b0};
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    busy_reg      <= 1'b1;
                    bcd_out_reg   <= scratch_reg;
                    sign_out_reg  <= sign_reg;
                    value_out_reg <= mag_reg;
                    done_reg      <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.SignValue = sign_out_reg;
    assign bus.Value     = value_out_reg;
    assign bus.Bcd       = bcd_out_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed and random checks of the signed BCD converter: reset, values, latency,
// busy/start handling, back-to-back throughput.
module tb_signed_bcd_converter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    signed_bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

    signed_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one conversion and waits (bounded) for done; leaves time at #1 after the done edge.
    task automatic run_conv(input logic [15:0] v, output int cycles);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Result = v;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.Result = 16'($urandom);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.SignValue !== 1'b0 || bus.Value !== 16'd0 || bus.Bcd !== 20'h0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: got sign=%b value=%0d bcd=%h busy=%b done=%b, want all 0",
                     bus.SignValue, bus.Value, bus.Bcd, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: outputs after 2-cycle reset sign=%b value=%0d bcd=%h", bus.SignValue, bus.Value, bus.Bcd);
    endtask

    task automatic test_positive();
        int cyc;
        run_conv(16'd1234, cyc);
        total++;
        if (cyc !== 17) begin
            bad++;
            $display("FAIL pos_latency: got %0d cycles, want 17", cyc);
        end
        total++;
        if (bus.Bcd !== 20'h01234 || bus.SignValue !== 1'b0 || bus.Value !== 16'd1234) begin
            bad++;
            $display("FAIL pos_1234: got bcd=%h sign=%b value=%0d, want 01234 0 1234", bus.Bcd, bus.SignValue, bus.Value);
        end
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_done: got %b, want 1", bus.busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_done: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
        $display("positive: 1234 -> bcd=%h sign=%b value=%0d latency=%0d", bus.Bcd, bus.SignValue, bus.Value, cyc);
    endtask

    task automatic test_negative();
        int cyc;
        run_conv(16'hFFFF, cyc);
        total++;
        if (bus.Bcd !== 20'h00001 || bus.SignValue !== 1'b1 || bus.Value !== 16'd1 || cyc !== 17) begin
            bad++;
            $display("FAIL neg_minus1: got bcd=%h sign=%b value=%0d cyc=%0d, want 00001 1 1 17",
                     bus.Bcd, bus.SignValue, bus.Value, cyc);
        end
        $display("negative: FFFF -> bcd=%h sign=%b value=%0d", bus.Bcd, bus.SignValue, bus.Value);
        run_conv(16'h8000, cyc);
        total++;
        if (bus.Bcd !== 20'h32768 || bus.SignValue !== 1'b1 || bus.Value !== 16'h8000) begin
            bad++;
            $display("FAIL neg_most: got bcd=%h sign=%b value=%h, want 32768 1 8000", bus.Bcd, bus.SignValue, bus.Value);
        end
        $display("negative: 8000 -> bcd=%h sign=%b value=%h", bus.Bcd, bus.SignValue, bus.Value);
    endtask

    task automatic test_extremes();
        int cyc;
        logic [19:0] b;
        run_conv(16'h7FFF, cyc);
        b = bus.Bcd;
        total++;
        if (bus.Bcd !== 20'h32767 || bus.SignValue !== 1'b0 || bus.Value !== 16'h7FFF) begin
            bad++;
            $display("FAIL max_pos: got bcd=%h sign=%b value=%h, want 32767 0 7fff", bus.Bcd, bus.SignValue, bus.Value);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b[i*4 +: 4] > 4'd9) begin
                bad++;
                $display("FAIL nibble_7fff: digit %0d got %h, want <=9", i, b[i*4 +: 4]);
            end
        end
        $display("extremes: 7FFF -> bcd=%h sign=%b", bus.Bcd, bus.SignValue);
        run_conv(16'h0000, cyc);
        total++;
        if (bus.Bcd !== 20'h0 || bus.SignValue !== 1'b0 || bus.Value !== 16'd0) begin
            bad++;
            $display("FAIL zero: got bcd=%h sign=%b value=%0d, want 0 0 0", bus.Bcd, bus.SignValue, bus.Value);
        end
        $display("extremes: 0000 -> bcd=%h sign=%b", bus.Bcd, bus.SignValue);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        int dones;
        run_conv(16'hFFFF, cyc);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Result = 16'd1234;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.Result = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Result = 16'hFFFB;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        dones = 0;
        for (int c = 3; c < 45; c++) begin
            if (bus.done === 1'b1) begin
                dones++;
                total++;
                if (bus.Bcd !== 20'h01234 || bus.SignValue !== 1'b0 || bus.Value !== 16'd1234) begin
                    bad++;
                    $display("FAIL ignore_result: got bcd=%h sign=%b value=%0d, want 01234 0 1234",
                             bus.Bcd, bus.SignValue, bus.Value);
                end
            end else if (dones == 0) begin
                if (bus.Bcd !== 20'h00001 || bus.SignValue !== 1'b1 || bus.Value !== 16'd1) begin
                    total++;
                    bad++;
                    $display("FAIL hold_prior: cycle %0d got bcd=%h sign=%b value=%0d, want 00001 1 1",
                             c, bus.Bcd, bus.SignValue, bus.Value);
                end
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (dones !== 1) begin
            bad++;
            $display("FAIL single_done: got %0d done pulses, want 1", dones);
        end
        $display("busy: start during SHIFT ignored, dones=%0d bcd=%h sign=%b", dones, bus.Bcd, bus.SignValue);
    endtask

    task automatic test_mid_reset();
        int dones;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Result = 16'd1234;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.SignValue !== 1'b0 || bus.Value !== 16'd0 || bus.Bcd !== 20'h0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got sign=%b value=%0d bcd=%h busy=%b done=%b, want all 0",
                     bus.SignValue, bus.Value, bus.Bcd, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL mid_reset_nodone: got %0d done pulses, want 0", dones);
        end
        $display("mid_reset: conversion aborted, dones afterwards=%0d", dones);
    endtask

    task automatic test_back_to_back();
        int d[4];
        int n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Result = 16'd42;
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (n < 4) d[n] = c;
                n++;
                total++;
                if (bus.Bcd !== 20'h00042) begin
                    bad++;
                    $display("FAIL b2b_value: got bcd=%h, want 00042", bus.Bcd);
                end
            end
        end
        bus.start = 1'b0;
        repeat (25) @(posedge clk);
        total++;
        if (n !== 4 || d[0] !== 17 || d[1] - d[0] !== 18 || d[2] - d[1] !== 18 || d[3] - d[2] !== 18) begin
            bad++;
            $display("FAIL b2b_spacing: got n=%0d at %0d %0d %0d %0d, want 4 at 17 35 53 71",
                     n, d[0], d[1], d[2], d[3]);
        end
        $display("back_to_back: %0d conversions, first done at %0d, spacing %0d", n, d[0], d[1] - d[0]);
    endtask

    task automatic test_random();
        int cyc;
        int errs;
        logic [15:0] v;
        logic        exp_sign;
        logic [15:0] exp_mag;
        logic [19:0] exp_bcd;
        int          m;
        errs = 0;
        for (int k = 0; k < 1000; k++) begin
            v = 16'($urandom);
            exp_sign = (v >= 16'h8000);
            exp_mag  = exp_sign ? 16'(17'h10000 - {1'b0, v}) : v;
            m = exp_mag;
            for (int i = 0; i < 5; i++) begin
                exp_bcd[i*4 +: 4] = 4'(m % 10);
                m = m / 10;
            end
            run_conv(v, cyc);
            total++;
            if (cyc !== 17 || bus.Bcd !== exp_bcd || bus.SignValue !== exp_sign || bus.Value !== exp_mag) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random %h: got bcd=%h sign=%b value=%h cyc=%0d, want %h %b %h 17",
                             v, bus.Bcd, bus.SignValue, bus.Value, cyc, exp_bcd, exp_sign, exp_mag);
            end
        end
        $display("random: 1000 conversions checked, errors=%0d", errs);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.Result = 16'h0000;
        test_reset();
        test_positive();
        test_negative();
        test_extremes();
        test_busy_ignore();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/signed_bcd_converter.md
# signed_bcd_converter

Sequential converter between the multiplier's signed 16-bit product and the seven-segment display stage. It captures a two's-complement result on `start`, splits it into sign and magnitude, and converts the magnitude to packed BCD with a shift-and-add-3 (double-dabble) loop, one bit per clock. Registered outputs feed the sign-segment decoder (`SignValue`, `Value`) and the per-digit segment decoders (`Bcd`). Outputs hold the previous result for the whole conversion, so the display never shows intermediate values.

## Interface
- `WIDTH`, default 16: input width, two's complement.
- `DIGITS`, default 5: number of BCD digits. Must satisfy 10^DIGITS > 2^(WIDTH-1).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `start`  in  1: request a conversion of `Result`. Sampled only in IDLE.
- `Result`  in  WIDTH: signed product to convert.
- `SignValue`  out  1: 1 when the captured `Result` was negative.
- `Value`  out  WIDTH: unsigned magnitude of the captured `Result`.
- `Bcd`  out  4*DIGITS: packed BCD of the magnitude. Digit 0 (units) is in [3:0].
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when new outputs become valid.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - On `start`=1: register sign = `Result[WIDTH-1]`.
  - Magnitude = `Result` if non-negative, else (~`Result`+1), computed in WIDTH bits, unsigned.
  - Load the magnitude into the binary shift register. Clear the BCD scratch. Set bit counter = WIDTH.
  - Go to SHIFT.
- **SHIFT** (one clock per step)
  - Each BCD scratch nibble ≥5 gets +3.
  - Then {scratch, binary} shifts left by 1 as one concatenated register. The binary MSB enters scratch bit 0.
  - Both steps happen in the same cycle. The counter decrements.
  - When the counter reaches 1 (last shift), go to DONE.
- **DONE**
  - Copy scratch to `Bcd`, the captured sign to `SignValue`, and the magnitude to `Value`.
  - Assert `done` for this cycle. Return to IDLE.
- Zero input gives `SignValue`=0 (no negative zero).
- Most-negative input (-2^(WIDTH-1)): magnitude 2^(WIDTH-1), represented exactly in WIDTH unsigned bits. `SignValue`=1.
- `start` while in SHIFT or DONE is ignored. No queuing. `Result` is not re-sampled.
- `Result` may change freely after the capture edge.
- `Bcd`, `SignValue` and `Value` change only in DONE. They hold their previous values otherwise.
- `busy`=1 in SHIFT and DONE, 0 in IDLE.

## Timing
- **Reset values:** `SignValue`=0, `Value`=0, `Bcd`=0, `busy`=0, `done`=0. State = IDLE; scratch and counter cleared.
- **Reset mid-conversion:** abort immediately to the reset values. Previously displayed outputs are also cleared.
- **Latency,** with `start` sampled at edge N:
  - SHIFT occupies cycles N+1..N+WIDTH.
  - New outputs and `done`=1 are visible after edge N+WIDTH+1.
  - For WIDTH=16: 17 cycles from the start edge to `done`.
- `busy` rises after edge N and falls after edge N+WIDTH+2, as IDLE is re-entered. It is still high during the `done` cycle.
- **Back-to-back:** the earliest next accepted `start` is at edge N+WIDTH+2. Throughput is one conversion per WIDTH+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `reset` 2 cycles → all outputs 0, `busy`=0. Assert `reset` at SHIFT cycle 8 of a conversion of 1234 → next cycle all outputs 0, no `done` pulse.
- **Positive:** `Result`=16'd1234 with `start` → `done` exactly 17 cycles after the start edge; `Bcd`=20'h01234, `SignValue`=0, `Value`=1234.
- **Negative:** `Result`=16'hFFFF (-1) → `Bcd`=20'h00001, `SignValue`=1, `Value`=1. `Result`=16'h8000 → `Bcd`=20'h32768, `SignValue`=1, `Value`=16'h8000.
- **Extremes:**
  - `Result`=16'h7FFF → `Bcd`=20'h32767, `SignValue`=0.
  - `Result`=0 → `Bcd`=0, `SignValue`=0, `Value`=0.
  - Each nibble ≤9 in all cases.
- **Busy handling:**
  - Start 1234. Pulse `start` with `Result`=-5 at SHIFT cycle 3 → result still 01234 positive, single `done`.
  - Outputs keep the prior conversion's values until the `done` cycle.
  - `start` held high continuously → conversions every 18 cycles.
- **Random:** 1000 random 16-bit `Result` values checked against a reference model of sign/abs/decimal digits.
